// File: rtl/prbs_checker.sv
// PRBS checker: seeds a local LFSR from the incoming stream, verifies it,
// then runs it free to count bit errors and drops lock on burst errors.
module prbs_checker #(
  parameter int N = 32,
  parameter logic [N-1:0] DEF_MASK = N'(32'h80200003),
  parameter int LOCK_CNT = 16,
  parameter int WIN = 64,
  parameter int LOSS_ERR = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic [N-1:0]     mask,
  input  logic             mask_ld,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int EW = $clog2(LOSS_ERR + 1);

  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     sh_q, sh_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    wbit_q, wbit_d;
  logic [EW-1:0]    werr_q, werr_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic [CNT_W-1:0] chkc_q, chkc_d;

  logic          pred;
  logic          miss;
  logic [EW-1:0] werr_n;

  assign pred   = ^(mask_q & sh_q);
  assign miss   = bit_in ^ pred;
  assign werr_n = werr_q + EW'(miss);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    match_d = match_q;
    wbit_d  = wbit_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    errc_d  = errc_q;
    chkc_d  = chkc_q;
    if (mask_ld) begin
      mask_d  = mask;
      state_d = SEED;
      fill_d  = '0;
      match_d = '0;
    end else if (bit_vld) begin
      unique case (state_q)
        SEED: begin
          sh_d = {sh_q[N-2:0], bit_in};
          if (fill_q == FW'(N - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        VERIFY: begin
          sh_d = {sh_q[N-2:0], bit_in};
          if (miss) begin
            state_d = SEED;
            fill_d  = '0;
          end else if (sh_q != '0) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              wbit_d  = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end
        end
        LOCKED: begin
          // Local reference runs free so line errors never enter sh
          sh_d = {sh_q[N-2:0], pred};
          if (chkc_q != '1) chkc_d = chkc_q + CNT_W'(1);
          if (miss) begin
            err_d = 1'b1;
            if (errc_q != '1) errc_d = errc_q + CNT_W'(1);
          end
          if (werr_n >= EW'(LOSS_ERR)) begin
            state_d = SEED;
            fill_d  = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else if (wbit_q == WW'(WIN - 1)) begin
            wbit_d = '0;
            werr_d = '0;
          end else begin
            wbit_d = wbit_q + WW'(1);
            werr_d = werr_n;
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (clr) begin
      errc_d = '0;
      chkc_d = '0;
    end
  end

  assign lock_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
      sh_q    <= '0;
      mask_q  <= DEF_MASK;
      fill_q  <= '0;
      match_q <= '0;
      wbit_q  <= '0;
      werr_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
      chkc_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      wbit_q  <= wbit_d;
      werr_q  <= werr_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
      chkc_q  <= chkc_d;
    end
  end

  assign locked  = lock_q;
  assign err     = err_q;
  assign err_cnt = errc_q;
  assign chk_cnt = chkc_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker at N=7 (PRBS7) with 4-bit counters, against a
// queue-based model of the acquire / verify / track behaviour.
module tb_prbs_checker;

  localparam int N = 7;
  localparam int LOCK_CNT = 16;
  localparam int WIN = 64;
  localparam int LOSS_ERR = 8;
  localparam int CNT_W = 4;
  localparam int SAT = 15;
  localparam logic [6:0] GMASK = 7'h60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_vld = 1'b0;
  logic [N-1:0] mask = '0;
  logic mask_ld = 1'b0;
  logic clr = 1'b0;
  logic locked;
  logic err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;

  prbs_checker #(
    .N(N),
    .DEF_MASK(GMASK),
    .LOCK_CNT(LOCK_CNT),
    .WIN(WIN),
    .LOSS_ERR(LOSS_ERR),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bit_in(bit_in),
    .bit_vld(bit_vld),
    .mask(mask),
    .mask_ld(mask_ld),
    .clr(clr),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt),
    .chk_cnt(chk_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int HUNT = 0;
  localparam int PROVE = 1;
  localparam int TRACK = 2;

  bit mh[$];
  logic [6:0] m_mask;
  int m_mode, m_fill, m_match, m_wb, m_we, m_ec, m_cc;
  bit m_err, m_lock;

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (m_mask[i]) p ^= mh[i];
    return p;
  endfunction

  function automatic bit m_zero();
    bit z = 1'b1;
    for (int i = 0; i < N; i++) if (mh[i]) z = 1'b0;
    return z;
  endfunction

  task automatic m_push(input bit b);
    mh.push_front(b);
    void'(mh.pop_back());
  endtask

  task automatic m_reset();
    mh.delete();
    for (int i = 0; i < N; i++) mh.push_back(1'b0);
    m_mask = GMASK;
    m_mode = HUNT;
    m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
    m_ec = 0; m_cc = 0; m_err = 0; m_lock = 0;
  endtask

  task automatic m_step();
    bit p, z, e;
    e = 1'b0;
    p = m_pred();
    z = m_zero();
    if (mask_ld) begin
      m_mask = mask;
      m_mode = HUNT;
      m_fill = 0;
      m_match = 0;
    end else if (bit_vld) begin
      if (m_mode == HUNT) begin
        m_push(bit_in);
        m_fill++;
        if (m_fill == N) begin
          m_mode = PROVE; m_fill = 0; m_match = 0;
        end
      end else if (m_mode == PROVE) begin
        m_push(bit_in);
        if (bit_in != p) begin
          m_mode = HUNT; m_fill = 0;
        end else if (!z) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_mode = TRACK; m_wb = 0; m_we = 0;
          end
        end
      end else begin
        m_push(p);
        m_cc = (m_cc < SAT) ? m_cc + 1 : SAT;
        if (bit_in != p) begin
          e = 1'b1;
          m_ec = (m_ec < SAT) ? m_ec + 1 : SAT;
        end
        m_wb++;
        m_we += int'(e);
        if (m_we >= LOSS_ERR) begin
          m_mode = HUNT; m_fill = 0;
        end
        if (m_wb == WIN || m_mode == HUNT) begin
          m_wb = 0; m_we = 0;
        end
      end
    end
    if (clr) begin
      m_ec = 0; m_cc = 0;
    end
    m_err = e;
    m_lock = (m_mode == TRACK);
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) m_reset();
    else m_step();
  end

  always @(negedge clk) begin
    check("locked", 32'(locked), 32'(m_lock));
    check("err", 32'(err), 32'(m_err));
    check("err_cnt", 32'(err_cnt), 32'(m_ec));
    check("chk_cnt", 32'(chk_cnt), 32'(m_cc));
  end

  // ---------------- stimulus ----------------
  logic [6:0] gs = 7'h01;

  task automatic send(input bit v, input bit flip, input bit c);
    bit b;
    b = 1'b0;
    if (v) begin
      b = ^(GMASK & gs);
      gs = {gs[5:0], b};
    end else begin
      b = 1'($urandom);
    end
    bit_in = b ^ flip;
    bit_vld = v;
    clr = c;
    mask_ld = 1'b0;
    mask = 7'($urandom);
    @(negedge clk);
  endtask

  task automatic load(input logic [6:0] m);
    mask_ld = 1'b1;
    mask = m;
    bit_vld = 1'($urandom);
    bit_in = 1'($urandom);
    clr = 1'b0;
    @(negedge clk);
    mask_ld = 1'b0;
  endtask

  task automatic acquire(input bit gaps, output int n);
    int cnt;
    int g;
    cnt = 0;
    n = -1;
    for (int c = 0; c < 400 && n < 0; c++) begin
      if (gaps) begin
        g = $urandom_range(0, 1) ? $urandom_range(1, 5) : 0;
        for (int k = 0; k < g; k++) send(1'b0, 1'b0, 1'b0);
      end
      send(1'b1, 1'b0, 1'b0);
      cnt++;
      if (locked) n = cnt;
    end
  endtask

  initial begin
    int n;
    int pulses;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_locked", 32'(locked), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    rst = 1'b1;

    load(7'h60);
    acquire(1'b0, n);
    check("first_lock_bits", n, 23);

    send(1'b1, 1'b0, 1'b1);
    repeat (10) send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    pulses = int'(err);
    repeat (40) begin
      send(1'b1, 1'b0, 1'b0);
      pulses += int'(err);
    end
    check("single_err_pulses", pulses, 1);
    check("single_err_cnt", 32'(err_cnt), 1);
    check("single_err_locked", 32'(locked), 1);

    repeat (20) send(1'b1, 1'b0, 1'b0);
    repeat (7) send(1'b1, 1'b1, 1'b0);
    check("burst7_locked", 32'(locked), 1);
    send(1'b1, 1'b1, 1'b0);
    check("burst8_locked", 32'(locked), 0);
    acquire(1'b0, n);
    check("relock_bits", n, 23);

    send(1'b1, 1'b0, 1'b1);
    repeat (20) begin
      repeat (15) send(1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0);
    end
    check("sat_err_cnt", 32'(err_cnt), 15);
    check("sat_locked", 32'(locked), 1);
    send(1'b1, 1'b1, 1'b1);
    check("clr_wins_err", 32'(err_cnt), 0);
    check("clr_wins_chk", 32'(chk_cnt), 0);

    load(7'h60);
    acquire(1'b1, n);
    check("gapped_lock_bits", n, 23);

    load(7'h60);
    send(1'b0, 1'b0, 1'b1);
    repeat (200) begin
      bit_in = 1'b0;
      bit_vld = 1'b1;
      clr = 1'b0;
      @(negedge clk);
    end
    check("zero_locked", 32'(locked), 0);
    check("zero_err_cnt", 32'(err_cnt), 0);

    load(7'h60);
    acquire(1'b0, n);
    check("pre_rst_locked", 32'(locked), 1);
    #2 rst = 1'b0;
    #1;
    check("async_locked", 32'(locked), 0);
    check("async_chk_cnt", 32'(chk_cnt), 0);
    check("async_err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b1;
    acquire(1'b0, n);
    check("post_rst_lock_bits", n, 23);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) load(7'($urandom));
      else if (r < 4) load(7'h60);
      else send($urandom_range(0, 4) != 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 32: LFSR length; shift-register and mask width.
REQ-002 Parameter DEF_MASK, default 32'h80200003: tap mask loaded at reset.
REQ-003 Parameter LOCK_CNT, default 16: consecutive matches needed to declare lock.
REQ-004 Parameter WIN / LOSS_ERR, default 64 / 8: a window of WIN checked bits containing LOSS_ERR or more errors drops lock.
REQ-005 Parameter CNT_W, default 32: width of err_cnt and chk_cnt.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset; asynchronous assert, active-low.
REQ-008 bit_in  input  1  received serial bit: the feedback bit of a Fibonacci LFSR, one per generator step.
REQ-009 bit_vld  input  1  bit_in is qualified this cycle; nothing advances while it is low.
REQ-010 mask  input  N  tap mask; captured only while mask_ld=1.
REQ-011 mask_ld  input  1  synchronous: capture mask and restart acquisition.
REQ-012 clr  input  1  synchronous: zero err_cnt and chk_cnt.
REQ-013 locked  output  1  checker is in LOCKED.
REQ-014 err  output  1  one-cycle pulse per errored checked bit.
REQ-015 err_cnt  output  CNT_W  saturating count of errored checked bits.
REQ-016 chk_cnt  output  CNT_W  saturating count of checked bits.

Function
REQ-017 sh[N-1:0] holds history with sh[0] newest; pred = XOR-reduce(mask_r & sh); every shift is sh <= {sh[N-2:0], b}.
REQ-018 The FSM has three states: SEED, VERIFY and LOCKED; no action is taken on a cycle with bit_vld=0.
REQ-019 In SEED, b = bit_in and fill increments; on the N-th valid bit the FSM goes to VERIFY with match count 0.
REQ-020 In VERIFY, b = bit_in; bit_in==pred increments match count; reaching LOCK_CNT moves to LOCKED on that same edge.
REQ-021 In VERIFY, a mismatch returns to SEED with fill=0; the bit is still shifted in.
REQ-022 In VERIFY, a bit evaluated while sh is all-zero does not increment match count (no false lock on a dead stream).
REQ-023 In LOCKED, b = pred (self-running reference), each valid bit increments chk_cnt, and bit_in!=pred increments err_cnt and pulses err on the next cycle.
REQ-024 In LOCKED, window counters count checked bits and errors; at LOSS_ERR errors within the window the FSM goes to SEED (fill=0) and locked drops on the same edge.
REQ-025 In LOCKED, the window counters restart after WIN checked bits.
REQ-026 The counters err_cnt and chk_cnt saturate at 2^CNT_W-1 and never wrap.
REQ-027 When clr coincides with an increment, clr wins: both counters read 0 next cycle.
REQ-028 mask_ld=1 loads mask_r, goes to SEED with fill=0 and match=0, and does not shift; it takes priority over bit_vld; err_cnt and chk_cnt are kept.
REQ-029 locked and err are registered; locked equals (state==LOCKED).

Reset
REQ-030 rst=0 forces asynchronously: state=SEED, sh=0, mask_r=DEF_MASK, fill=0, match=0, window counters=0, locked=0, err=0, err_cnt=0, chk_cnt=0.
REQ-031 Reset asserted mid-operation discards all progress; after release, acquisition restarts from SEED.

Verification
REQ-032 N=7, mask_ld with 7'h60, continuous PRBS7 stream -> locked=1 on the edge of the 7+LOCK_CNT-th valid bit; err_cnt stays 0.
REQ-033 Locked at N=7, one bit_in inverted -> single err pulse, err_cnt=1, locked stays 1, following bits check clean (no error multiplication).
REQ-034 Locked, 8 inverted bits within 64 -> locked=0 on the 8th error; a clean stream then relocks after 7+16 valid bits.
REQ-035 All-zero stream with bit_vld=1 for 200 cycles -> locked stays 0, err_cnt=0.
REQ-036 CNT_W=4, locked, 20 errored bits spaced beyond the loss rule -> err_cnt saturates at 15; clr with an error the same cycle -> err_cnt=0.
REQ-037 Reset asserted while locked -> all outputs 0 immediately without a clock edge; bit_vld gaps of 1-5 cycles during acquisition do not change lock timing in valid-bit counts.
